// File: rtl/featuremap_conv2d_multich.sv
// Multi-channel 3x3 convolution over a pre-padded raster stream: line buffers,
// a 5-stage signed MAC pipeline, saturation/ReLU and frame-position tracking.
module featuremap_conv2d_multich #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int NUM_CH     = 3,
    parameter int IMG_W      = 114,
    parameter int IMG_H      = 114,
    parameter logic [NUM_CH*9*COEF_WIDTH-1:0] KERNELS = '0,
    parameter logic signed [DATA_WIDTH-1:0]   BIAS    = '0,
    parameter bit RELU_EN = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         data_fifo_empty,
    input  logic                         out_full,
    output logic                         rdreq,
    output logic                         valid_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         frame_done
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int CHS_W  = PROD_W + 4;
    localparam int ACC_W  = PROD_W + $clog2(9 * NUM_CH) + 1;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    typedef logic signed [DATA_WIDTH-1:0] pix_t;
    typedef logic signed [COEF_WIDTH-1:0] coef_t;
    typedef logic signed [PROD_W-1:0]     prod_t;
    typedef logic signed [CHS_W-1:0]      chs_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);
    localparam acc_t SAT_MAX = (acc_t'(1) <<< (DATA_WIDTH - 1)) - acc_t'(1);
    localparam acc_t SAT_MIN = -(acc_t'(1) <<< (DATA_WIDTH - 1));

    function automatic coef_t coef(input int c, input int k);
        return coef_t'(KERNELS[(c*9+k)*COEF_WIDTH +: COEF_WIDTH]);
    endfunction

    logic             en;
    logic             accept;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_ok;
    logic             pix_last;

    pix_t  pix_in   [NUM_CH];
    pix_t  lb1_q    [NUM_CH][IMG_W];
    pix_t  lb2_q    [NUM_CH][IMG_W];
    pix_t  win_q    [NUM_CH][9];
    pix_t  s1_win_q [NUM_CH][9];
    prod_t prod_d   [NUM_CH][9];
    prod_t prod_q   [NUM_CH][9];
    chs_t  chs_d    [NUM_CH];
    chs_t  chs_q    [NUM_CH];
    acc_t  total;
    acc_t  s4_d, s4_q;
    pix_t  res_d;
    pix_t  data_q;

    logic acc_v_q, acc_last_q;
    logic s1_v_q,  s1_last_q;
    logic s2_v_q,  s2_last_q;
    logic s3_v_q,  s3_last_q;
    logic s4_v_q,  s4_last_q;
    logic valid_q, frame_done_q;

    // NOTE: rdreq is combinational so the FIFO pops in the same cycle the beat is consumed.
    assign en     = ~out_full;
    assign accept = ~data_fifo_empty & en;
    assign rdreq  = accept;

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
        win_ok   = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
        pix_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            pix_in[c] = pix_t'(data_in[c*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // S2 products are full width, so no precision is lost before the final shift.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 9; k++) begin
                prod_d[c][k] = prod_t'(s1_win_q[c][k]) * prod_t'(coef(c, k));
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            chs_d[c] = '0;
            for (int k = 0; k < 9; k++) begin
                chs_d[c] = chs_d[c] + chs_t'(prod_q[c][k]);
            end
        end
    end

    always_comb begin
        total = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            total = total + acc_t'(chs_q[c]);
        end
        s4_d = (total >>> FRAC_BITS) + acc_t'(BIAS);
    end

    always_comb begin
        res_d = pix_t'(s4_q);
        if (s4_q > SAT_MAX) begin
            res_d = pix_t'(SAT_MAX);
        end else if (s4_q < SAT_MIN) begin
            res_d = pix_t'(SAT_MIN);
        end
        if (RELU_EN && res_d[DATA_WIDTH-1]) begin
            res_d = '0;
        end
    end

    // NOTE: line buffers, window and datapath registers carry no reset; the
    // valid bits alone decide whether their contents are ever used.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                lb2_q[c][col_q] <= lb1_q[c][col_q];
                lb1_q[c][col_q] <= pix_in[c];
                win_q[c][0]     <= win_q[c][1];
                win_q[c][1]     <= win_q[c][2];
                win_q[c][2]     <= lb2_q[c][col_q];
                win_q[c][3]     <= win_q[c][4];
                win_q[c][4]     <= win_q[c][5];
                win_q[c][5]     <= lb1_q[c][col_q];
                win_q[c][6]     <= win_q[c][7];
                win_q[c][7]     <= win_q[c][8];
                win_q[c][8]     <= pix_in[c];
            end
        end
        if (en) begin
            s1_win_q <= win_q;
            prod_q   <= prod_d;
            chs_q    <= chs_d;
            s4_q     <= s4_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            acc_v_q      <= 1'b0;
            acc_last_q   <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_v_q       <= 1'b0;
            s2_last_q    <= 1'b0;
            s3_v_q       <= 1'b0;
            s3_last_q    <= 1'b0;
            s4_v_q       <= 1'b0;
            s4_last_q    <= 1'b0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= '0;
        end else if (en) begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            acc_v_q      <= accept & win_ok;
            acc_last_q   <= accept & pix_last;
            s1_v_q       <= acc_v_q;
            s1_last_q    <= acc_last_q;
            s2_v_q       <= s1_v_q;
            s2_last_q    <= s1_last_q;
            s3_v_q       <= s2_v_q;
            s3_last_q    <= s2_last_q;
            s4_v_q       <= s3_v_q;
            s4_last_q    <= s3_last_q;
            valid_q      <= s4_v_q;
            frame_done_q <= s4_v_q & s4_last_q;
            if (s4_v_q) begin
                data_q <= res_d;
            end
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_featuremap_conv2d_multich.sv
// Bench for featuremap_conv2d_multich: constant-frame vector table across several
// configurations, plus a stalled multi-frame stream and a mid-frame reset.
module tb_featuremap_conv2d_multich;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- group 1: constant-pixel frames, one instance per config
    typedef struct {
        string name;
        int    pix;
        int    exp_val;
    } vec_t;

    vec_t tbl [7];

    logic        empty1, full1;
    int          pix_v   [7];
    logic        rdreq_w [7];
    logic        valid_w [7];
    logic        fd_w    [7];
    int          dout_w  [7];

    logic [31:0] din_a, din_b, din_c;
    logic [7:0]  din_d, din_e;
    logic [15:0] din_fp, din_fn;
    logic [15:0] do_a, do_b, do_c, do_fp, do_fn;
    logic [7:0]  do_d, do_e;

    assign din_a  = {2{pix_v[0][15:0]}};
    assign din_b  = {2{pix_v[1][15:0]}};
    assign din_c  = {2{pix_v[2][15:0]}};
    assign din_d  = pix_v[3][7:0];
    assign din_e  = pix_v[4][7:0];
    assign din_fp = pix_v[5][15:0];
    assign din_fn = pix_v[6][15:0];

    assign dout_w[0] = {{16{do_a[15]}}, do_a};
    assign dout_w[1] = {{16{do_b[15]}}, do_b};
    assign dout_w[2] = {{16{do_c[15]}}, do_c};
    assign dout_w[3] = {{24{do_d[7]}}, do_d};
    assign dout_w[4] = {{24{do_e[7]}}, do_e};
    assign dout_w[5] = {{16{do_fp[15]}}, do_fp};
    assign dout_w[6] = {{16{do_fn[15]}}, do_fn};

    featuremap_conv2d_multich #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(0), .NUM_CH(2),
        .IMG_W(5), .IMG_H(4), .KERNELS({18{16'h0001}}), .BIAS(16'h0000), .RELU_EN(1'b0))
    u_a (.clk(clk), .rst(rst), .data_in(din_a), .data_fifo_empty(empty1), .out_full(full1),
         .rdreq(rdreq_w[0]), .valid_out(valid_w[0]), .data_out(do_a), .frame_done(fd_w[0]));

    featuremap_conv2d_multich #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(0), .NUM_CH(2),
        .IMG_W(5), .IMG_H(4), .KERNELS({18{16'h0001}}), .BIAS(16'hFFEC), .RELU_EN(1'b1))
    u_b (.clk(clk), .rst(rst), .data_in(din_b), .data_fifo_empty(empty1), .out_full(full1),
         .rdreq(rdreq_w[1]), .valid_out(valid_w[1]), .data_out(do_b), .frame_done(fd_w[1]));

    featuremap_conv2d_multich #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(0), .NUM_CH(2),
        .IMG_W(5), .IMG_H(4), .KERNELS({18{16'h0001}}), .BIAS(16'hFFEC), .RELU_EN(1'b0))
    u_c (.clk(clk), .rst(rst), .data_in(din_c), .data_fifo_empty(empty1), .out_full(full1),
         .rdreq(rdreq_w[2]), .valid_out(valid_w[2]), .data_out(do_c), .frame_done(fd_w[2]));

    featuremap_conv2d_multich #(.DATA_WIDTH(8), .COEF_WIDTH(8), .FRAC_BITS(0), .NUM_CH(1),
        .IMG_W(5), .IMG_H(4), .KERNELS({9{8'h7F}}), .BIAS(8'h00), .RELU_EN(1'b0))
    u_d (.clk(clk), .rst(rst), .data_in(din_d), .data_fifo_empty(empty1), .out_full(full1),
         .rdreq(rdreq_w[3]), .valid_out(valid_w[3]), .data_out(do_d), .frame_done(fd_w[3]));

    featuremap_conv2d_multich #(.DATA_WIDTH(8), .COEF_WIDTH(8), .FRAC_BITS(0), .NUM_CH(1),
        .IMG_W(5), .IMG_H(4), .KERNELS({9{8'h80}}), .BIAS(8'h00), .RELU_EN(1'b0))
    u_e (.clk(clk), .rst(rst), .data_in(din_e), .data_fifo_empty(empty1), .out_full(full1),
         .rdreq(rdreq_w[4]), .valid_out(valid_w[4]), .data_out(do_e), .frame_done(fd_w[4]));

    featuremap_conv2d_multich #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(8), .NUM_CH(1),
        .IMG_W(5), .IMG_H(4), .KERNELS({16'h0080, 128'h0}), .BIAS(16'h0000), .RELU_EN(1'b0))
    u_fp (.clk(clk), .rst(rst), .data_in(din_fp), .data_fifo_empty(empty1), .out_full(full1),
          .rdreq(rdreq_w[5]), .valid_out(valid_w[5]), .data_out(do_fp), .frame_done(fd_w[5]));

    featuremap_conv2d_multich #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(8), .NUM_CH(1),
        .IMG_W(5), .IMG_H(4), .KERNELS({16'h0080, 128'h0}), .BIAS(16'h0000), .RELU_EN(1'b0))
    u_fn (.clk(clk), .rst(rst), .data_in(din_fn), .data_fifo_empty(empty1), .out_full(full1),
          .rdreq(rdreq_w[6]), .valid_out(valid_w[6]), .data_out(do_fn), .frame_done(fd_w[6]));

    int       cnt1   [7] = '{default: 0};
    int       obs_v  [7][8];
    int       fd_pos [7] = '{default: -1};
    int       fd_cnt [7] = '{default: 0};
    int       first_valid_cyc = -1;
    int       acc_edge = -1;
    logic [7:0] pat = '0;
    int       pat_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                if (valid_w[i] && !full1) begin
                    if (cnt1[i] < 8) obs_v[i][cnt1[i]] = dout_w[i];
                    if (fd_w[i]) begin
                        fd_cnt[i]++;
                        fd_pos[i] = cnt1[i];
                    end
                    cnt1[i]++;
                end
            end
            if (valid_w[0] && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (first_valid_cyc >= 0 && pat_n < 8) begin
                pat = {pat[6:0], valid_w[0]};
                pat_n++;
            end
        end
    end

    // ---------------- group 2: random stalls, three frames, then mid-frame reset
    localparam int GF = 5;

    function automatic logic [287:0] mk_taps();
        logic [287:0] v;
        v = '0;
        for (int i = 0; i < 18; i++) v[i*16 +: 16] = 16'((i % 7) - 3);
        return v;
    endfunction

    localparam logic [287:0] G_TAPS = mk_taps();

    logic        empty_g, full_g, rdreq_g, valid_g, fd_g;
    logic [31:0] data_g;
    logic [15:0] do_g;

    featuremap_conv2d_multich #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(2), .NUM_CH(2),
        .IMG_W(5), .IMG_H(4), .KERNELS(G_TAPS), .BIAS(16'hFFDB), .RELU_EN(1'b0))
    u_g (.clk(clk), .rst(rst), .data_in(data_g), .data_fifo_empty(empty_g), .out_full(full_g),
         .rdreq(rdreq_g), .valid_out(valid_g), .data_out(do_g), .frame_done(fd_g));

    int gpix [GF][2][4][5];
    int exp_q [$];
    bit exp_fd_q [$];

    function automatic int tap_val(input int c, input int k);
        return ((c * 9 + k) % 7) - 3;
    endfunction

    function automatic int model(input int f, input int r, input int c);
        int s;
        s = 0;
        for (int ch = 0; ch < 2; ch++)
            for (int k = 0; k < 9; k++)
                s += tap_val(ch, k) * gpix[f][ch][r-2+k/3][c-2+k%3];
        s = (s >>> 2) - 37;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic push_frame(input int f);
        for (int r = 2; r < 4; r++)
            for (int c = 2; c < 5; c++) begin
                exp_q.push_back(model(f, r, c));
                exp_fd_q.push_back(r == 3 && c == 4);
            end
    endtask

    task automatic stream_g(input int f, input int nbeats, input int stall_pct);
        int b;
        int budget;
        b = 0;
        budget = 0;
        while (b < nbeats && budget < 3000) begin
            @(posedge clk); #1;
            full_g  = ($urandom_range(99) < stall_pct);
            empty_g = ($urandom_range(99) < stall_pct);
            data_g  = {16'(gpix[f][1][b/5][b%5]), 16'(gpix[f][0][b/5][b%5])};
            if (!empty_g && !full_g) b++;
            budget++;
        end
        if (b < nbeats) check("g_stream_timeout", b, nbeats);
    endtask

    task automatic drain_g(input string tag);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
            empty_g = 1'b1;
            full_g  = ($urandom_range(99) < 30);
        end
        @(posedge clk); #1;
        full_g = 1'b0;
        repeat (10) @(posedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    logic       prev_full_g = 1'b0, prev_valid_g = 1'b0, prev_fd_g = 1'b0;
    logic [15:0] prev_do_g = '0;
    int hold_viol = 0, hold_samples = 0, rd_viol = 0;

    always @(negedge clk) begin
        int  e;
        bit  ef;
        if (rst) begin
            if (prev_full_g) begin
                hold_samples++;
                if (valid_g !== prev_valid_g || do_g !== prev_do_g || fd_g !== prev_fd_g) hold_viol++;
            end
            if (rdreq_g !== (!empty_g && !full_g)) rd_viol++;
            if (valid_g && !full_g) begin
                if (exp_q.size() == 0) begin
                    check("g_unexpected_output", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    ef = exp_fd_q.pop_front();
                    check("g_data", $signed(do_g), e);
                    check("g_frame_done", fd_g, ef);
                end
            end
        end
        prev_full_g  = full_g & rst;
        prev_valid_g = valid_g;
        prev_fd_g    = fd_g;
        prev_do_g    = do_g;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{"sum_taps1",   1,    18};
        tbl[1] = '{"bias_relu",   1,     0};
        tbl[2] = '{"bias_norelu", 1,    -2};
        tbl[3] = '{"sat_pos",     127,  127};
        tbl[4] = '{"sat_neg",     127, -128};
        tbl[5] = '{"frac_pos",    3,     1};
        tbl[6] = '{"frac_neg",    -3,   -2};

        rst = 1'b0;
        empty1 = 1'b1; full1 = 1'b0;
        empty_g = 1'b1; full_g = 1'b0; data_g = '0;
        for (int i = 0; i < 7; i++) pix_v[i] = tbl[i].pix;
        for (int f = 0; f < GF; f++)
            for (int ch = 0; ch < 2; ch++)
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 5; c++)
                        gpix[f][ch][r][c] = int'($urandom_range(200)) - 100;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++)
            check({tbl[i].name, "_reset_state"},
                  int'(valid_w[i]) + 2 * int'(fd_w[i]) + 4 * int'(dout_w[i] != 0), 0);
        check("g_reset_state", int'(valid_g) + 2 * int'(fd_g) + 4 * int'(do_g != 0), 0);
        check("rdreq_empty", int'(rdreq_w[0]), 0);
        rst = 1'b1;

        for (int b = 0; b < 20; b++) begin
            @(posedge clk); #1;
            empty1 = 1'b0;
            if (b == 12) acc_edge = cyc + 1;
        end
        @(posedge clk); #1;
        empty1 = 1'b1;
        repeat (15) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            check({tbl[i].name, "_count"}, cnt1[i], 6);
            for (int j = 0; j < 6; j++) check({tbl[i].name, "_value"}, obs_v[i][j], tbl[i].exp_val);
            check({tbl[i].name, "_frame_done_pos"}, fd_pos[i], 5);
            check({tbl[i].name, "_frame_done_cnt"}, fd_cnt[i], 1);
        end
        check("latency_first_valid", first_valid_cyc - acc_edge, 5);
        check("valid_pattern", pat, 8'b1110_0111);

        empty1 = 1'b0;
        full1  = 1'b1;
        #1;
        check("rdreq_while_full", int'(rdreq_w[0]), 0);
        full1 = 1'b0;
        #1;
        check("rdreq_ready", int'(rdreq_w[0]), 1);
        empty1 = 1'b1;

        for (int f = 0; f < 3; f++) push_frame(f);
        for (int f = 0; f < 3; f++) stream_g(f, 20, 30);
        drain_g("g_three_frames_drained");

        stream_g(3, 14, 0);
        @(posedge clk); #1;
        empty_g = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        push_frame(4);
        stream_g(4, 20, 30);
        drain_g("g_after_reset_drained");

        check("g_hold_violations", hold_viol, 0);
        check("g_hold_samples_seen", int'(hold_samples > 0), 1);
        check("g_rdreq_violations", rd_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
